// File: rtl/multi_player_timer_pkg.sv
// Shared types and constants for the multi-player game clock.
// Holds the controller state encoding and the min:sec field limits.
package multi_player_timer_pkg;

    localparam int          FW      = 6;
    localparam logic [5:0]  SEC_MAX = 6'd59;
    localparam logic [5:0]  MIN_SAT = 6'd63;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_FLAG  = 2'd3
    } state_t;

    function automatic logic [FW-1:0] clamp59(input logic [FW-1:0] v);
        return (v > SEC_MAX) ? SEC_MAX : v;
    endfunction

endpackage

// File: rtl/mm_ss_unit.sv
// One player's min:sec register with decrement, saturating increment and zero detect.
// When decrement and increment are both requested, the decrement is applied first.
module mm_ss_unit
    import multi_player_timer_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [FW-1:0] load_min,
    input  logic          dec,
    input  logic          add,
    input  logic [FW-1:0] add_sec,
    output logic [FW-1:0] min,
    output logic [FW-1:0] sec,
    output logic          is_zero,
    output logic          dec_hits_zero
);

    logic [FW-1:0] dmin, dsec, amin, asec;
    logic [FW:0]   sec_sum, min_sum;

    always_comb begin
        dmin    = min;
        dsec    = sec;
        amin    = min;
        asec    = sec;
        sec_sum = '0;
        min_sum = '0;
        if (dec) begin
            if (sec != '0) begin
                dsec = sec - 6'd1;
            end else if (min != '0) begin
                dmin = min - 6'd1;
                dsec = SEC_MAX;
            end
        end
        amin = dmin;
        asec = dsec;
        if (add) begin
            sec_sum = {1'b0, dsec} + {1'b0, add_sec};
            if (sec_sum >= 7'd60) begin
                asec    = FW'(sec_sum - 7'd60);
                min_sum = {1'b0, dmin} + 7'd1;
            end else begin
                asec    = sec_sum[FW-1:0];
                min_sum = {1'b0, dmin};
            end
            // A carry past the widest minute field pins the clock at its ceiling.
            if (min_sum > {1'b0, MIN_SAT}) begin
                amin = MIN_SAT;
                asec = SEC_MAX;
            end else begin
                amin = min_sum[FW-1:0];
            end
        end
    end

    assign is_zero       = (min == '0) && (sec == '0);
    assign dec_hits_zero = (min == '0) && (sec == 6'd1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            min <= '0;
            sec <= '0;
        end else if (load) begin
            min <= load_min;
            sec <= '0;
        end else if (dec || add) begin
            min <= amin;
            sec <= asec;
        end
    end

endmodule

// File: rtl/multi_player_timer.sv
// Multi-player game clock controller: one min:sec clock per player, one running at a time.
//  state    | meaning
//  ST_IDLE  | clocks loaded or zeroed, waiting for start
//  ST_RUN   | active player's clock counts down once per tick
//  ST_PAUSE | counting frozen, resumable
//  ST_FLAG  | a clock expired; only load leaves
module multi_player_timer
    import multi_player_timer_pkg::*;
#(
    parameter int N_PLAYERS = 2,
    parameter int TICK_DIV  = 100000000,
    parameter int PW        = $clog2(N_PLAYERS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [5:0]              init_min,
    input  logic [5:0]              inc_sec,
    input  logic                    mode,
    input  logic                    start,
    input  logic                    pause,
    input  logic                    pass,
    output logic [PW-1:0]           active,
    output logic                    running,
    output logic [N_PLAYERS-1:0]    flag,
    output logic [6*N_PLAYERS-1:0]  min_bus,
    output logic [6*N_PLAYERS-1:0]  sec_bus
);

    localparam int CW = $clog2(TICK_DIV);

    state_t                 state, state_next;
    logic [CW-1:0]          presc, presc_next;
    logic [PW-1:0]          active_next;
    logic [N_PLAYERS-1:0]   flag_next;
    logic                   load_en, tick, any_live, act_hits_zero;
    logic [N_PLAYERS-1:0]   act_onehot, dec_vec, add_vec, zero_vec, hits_vec;
    logic [FW-1:0]          min_w [N_PLAYERS];
    logic [FW-1:0]          sec_w [N_PLAYERS];
    logic [FW-1:0]          load_min, add_sec;

    assign load_min = clamp59(init_min);
    assign add_sec  = clamp59(inc_sec);

    for (genvar p = 0; p < N_PLAYERS; p++) begin : g_player
        mm_ss_unit u_clk (
            .clk           (clk),
            .reset         (reset),
            .load          (load_en),
            .load_min      (load_min),
            .dec           (dec_vec[p]),
            .add           (add_vec[p]),
            .add_sec       (add_sec),
            .min           (min_w[p]),
            .sec           (sec_w[p]),
            .is_zero       (zero_vec[p]),
            .dec_hits_zero (hits_vec[p])
        );
        assign min_bus[6*p +: 6] = min_w[p];
        assign sec_bus[6*p +: 6] = sec_w[p];
        assign act_onehot[p]     = (active == PW'(p));
    end

    assign any_live      = ~&zero_vec;
    assign act_hits_zero = |(hits_vec & act_onehot);
    assign tick          = (presc == CW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next  = state;
        presc_next  = presc;
        active_next = active;
        flag_next   = flag;
        load_en     = 1'b0;
        dec_vec     = '0;
        add_vec     = '0;
        case (state)
            ST_IDLE: begin
                if (load) begin
                    load_en     = 1'b1;
                    flag_next   = '0;
                    active_next = '0;
                end else if (start && !pause && any_live) begin
                    state_next = ST_RUN;
                    presc_next = '0;
                end
            end
            ST_RUN: begin
                if (!pause) begin
                    if (tick) dec_vec = act_onehot;
                    // An expiring decrement wins over a simultaneous pass.
                    if (tick && act_hits_zero) begin
                        flag_next  = flag | act_onehot;
                        state_next = ST_FLAG;
                        presc_next = '0;
                    end else if (pass) begin
                        if (mode) add_vec = act_onehot;
                        active_next = (active == PW'(N_PLAYERS - 1)) ? '0 : active + PW'(1);
                        presc_next  = '0;
                    end else begin
                        presc_next = tick ? '0 : presc + CW'(1);
                    end
                end else begin
                    state_next = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (load) begin
                    load_en     = 1'b1;
                    flag_next   = '0;
                    active_next = '0;
                    state_next  = ST_IDLE;
                end else if (start && !pause) begin
                    state_next = ST_RUN;
                    presc_next = '0;
                end
            end
            ST_FLAG: begin
                if (load) begin
                    load_en     = 1'b1;
                    flag_next   = '0;
                    active_next = '0;
                    state_next  = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            presc   <= '0;
            active  <= '0;
            flag    <= '0;
            running <= 1'b0;
        end else begin
            presc   <= presc_next;
            active  <= active_next;
            flag    <= flag_next;
            running <= (state_next == ST_RUN);
        end
    end

endmodule

// File: tb/tb_multi_player_timer.sv
// Directed self-checking bench for multi_player_timer with three players and a 4-cycle tick.
module tb_multi_player_timer;

    localparam int N  = 3;
    localparam int TD = 4;
    localparam int PW = $clog2(N);

    logic            clk = 1'b0;
    logic            reset, load, mode, start, pause, pass;
    logic [5:0]      init_min, inc_sec;
    logic [PW-1:0]   active;
    logic            running;
    logic [N-1:0]    flag;
    logic [6*N-1:0]  min_bus, sec_bus;

    int n_checks = 0;
    int n_fail   = 0;

    multi_player_timer #(.N_PLAYERS(N), .TICK_DIV(TD)) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .init_min (init_min),
        .inc_sec  (inc_sec),
        .mode     (mode),
        .start    (start),
        .pause    (pause),
        .pass     (pass),
        .active   (active),
        .running  (running),
        .flag     (flag),
        .min_bus  (min_bus),
        .sec_bus  (sec_bus)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_clk(input string tag, input int p, input int m, input int s);
        chk({tag, "_min"}, 32'(min_bus[6*p +: 6]), 32'(m));
        chk({tag, "_sec"}, 32'(sec_bus[6*p +: 6]), 32'(s));
    endtask

    initial begin
        reset = 1'b0; load = 1'b0; mode = 1'b0; start = 1'b0; pause = 1'b0; pass = 1'b0;
        init_min = '0; inc_sec = '0;
        cyc(2);
        chk("rst_running", 32'(running), 0);
        chk("rst_active",  32'(active),  0);
        chk("rst_flag",    32'(flag),    0);
        chk("rst_min_bus", 32'(min_bus), 0);
        chk("rst_sec_bus", 32'(sec_bus), 0);
        reset = 1'b1;

        start = 1'b1; cyc(); start = 1'b0;
        chk("start_no_load", 32'(running), 0);

        init_min = 6'd1; load = 1'b1; cyc(); load = 1'b0;
        chk("load_min_bus", 32'(min_bus), 32'({6'd1, 6'd1, 6'd1}));
        chk("load_sec_bus", 32'(sec_bus), 0);

        start = 1'b1; cyc(); start = 1'b0;
        chk("run_entry", 32'(running), 1);
        cyc(3);
        chk_clk("pre_tick_p0", 0, 1, 0);
        cyc();
        chk_clk("tick_p0", 0, 0, 59);
        chk_clk("tick_p1", 1, 1, 0);
        chk_clk("tick_p2", 2, 1, 0);

        cyc(16);
        chk_clk("p0_at_55", 0, 0, 55);
        mode = 1'b1; inc_sec = 6'd10; pass = 1'b1; cyc(); pass = 1'b0;
        chk_clk("fischer_carry_p0", 0, 1, 5);
        chk("pass_active_1", 32'(active), 1);
        cyc(3);
        chk_clk("fresh_sec_p1", 1, 1, 0);
        cyc();
        chk_clk("first_tick_p1", 1, 0, 59);
        chk_clk("idle_p0_kept", 0, 1, 5);

        pass = 1'b1; cyc();
        chk("pass_active_2", 32'(active), 2);
        chk_clk("fischer_p1", 1, 1, 9);
        cyc(); pass = 1'b0;
        chk("pass_wrap", 32'(active), 0);
        chk_clk("fischer_p2", 2, 1, 10);

        cyc(220);
        chk_clk("p0_at_10", 0, 0, 10);
        cyc(3);
        chk_clk("p0_still_10", 0, 0, 10);
        inc_sec = 6'd5; pass = 1'b1; cyc(); pass = 1'b0;
        chk_clk("tick_and_pass_p0", 0, 0, 14);
        chk("tick_and_pass_active", 32'(active), 1);

        pause = 1'b1; pass = 1'b1; cyc(); pause = 1'b0; pass = 1'b0;
        chk("pause_pass_running", 32'(running), 0);
        chk("pause_pass_active", 32'(active), 1);
        chk_clk("pause_pass_p1", 1, 1, 9);

        start = 1'b1; pause = 1'b1; cyc(); pause = 1'b0;
        chk("start_pause_running", 32'(running), 0);
        cyc(); start = 1'b0;
        chk("resume_running", 32'(running), 1);

        cyc(272);
        chk_clk("p1_at_01", 1, 0, 1);
        chk("no_flag_yet", 32'(flag), 0);
        cyc(3);
        chk_clk("p1_still_01", 1, 0, 1);
        cyc();
        chk_clk("p1_expired", 1, 0, 0);
        chk("flag_p1", 32'(flag), 32'(3'b010));
        chk("flag_running", 32'(running), 0);
        chk_clk("flag_p0_kept", 0, 0, 14);
        chk_clk("flag_p2_kept", 2, 1, 10);

        pass = 1'b1; start = 1'b1; cyc(2); pass = 1'b0; start = 1'b0;
        chk("flag_hold", 32'(flag), 32'(3'b010));
        chk("flag_hold_active", 32'(active), 1);
        chk("flag_hold_running", 32'(running), 0);

        init_min = 6'd63; load = 1'b1; cyc(); load = 1'b0;
        chk("reload_flag", 32'(flag), 0);
        chk("reload_active", 32'(active), 0);
        chk("reload_clamp", 32'(min_bus), 32'({6'd59, 6'd59, 6'd59}));

        inc_sec = 6'd63; start = 1'b1; cyc(); start = 1'b0;
        pass = 1'b1; cyc(21); pass = 1'b0;
        chk_clk("sat_p0", 0, 63, 59);
        chk_clk("sat_p2", 2, 63, 59);
        chk("sat_active", 32'(active), 0);

        mode = 1'b0; pass = 1'b1; cyc(); pass = 1'b0;
        chk("sd_active", 32'(active), 1);
        chk_clk("sd_p0_kept", 0, 63, 59);
        chk("sd_running", 32'(running), 1);

        reset = 1'b0; cyc(); reset = 1'b1;
        chk("midrun_rst_running", 32'(running), 0);
        chk("midrun_rst_active",  32'(active),  0);
        chk("midrun_rst_min_bus", 32'(min_bus), 0);
        chk("midrun_rst_sec_bus", 32'(sec_bus), 0);
        start = 1'b1; cyc(); start = 1'b0;
        chk("post_rst_start", 32'(running), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_player_timer.md
MULTI_PLAYER_TIMER -- requirements
Module: multi_player_timer

Interface
REQ-001 Parameter N_PLAYERS, default 2, number of player clocks; legal range 2..8.
REQ-002 Parameter TICK_DIV, default 100000000, clk cycles per one-second tick; minimum 2.
REQ-003 Parameter PW, default $clog2(N_PLAYERS), width of player index.
REQ-004 clk  in  1  single system clock; all logic rising-edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 load  in  1  one-cycle pulse; copies init_min:00 into every player clock.
REQ-007 init_min  in  6  initial minutes, 0..59; values above 59 treated as 59.
REQ-008 inc_sec  in  6  Fischer increment seconds, 0..59; values above 59 treated as 59.
REQ-009 mode  in  1  0 = sudden death, 1 = Fischer increment on pass.
REQ-010 start  in  1  one-cycle pulse; begin or resume counting.
REQ-011 pause  in  1  one-cycle pulse; freeze counting.
REQ-012 pass  in  1  one-cycle pulse; active player ends move.
REQ-013 active  out  PW  index of player whose clock runs.
REQ-014 running  out  1  high in RUN state.
REQ-015 flag  out  N_PLAYERS  bit p high when player p's clock has expired.
REQ-016 min_bus  out  6*N_PLAYERS  minutes; player p at bits [6p+5:6p].
REQ-017 sec_bus  out  6*N_PLAYERS  seconds 0..59; player p at bits [6p+5:6p].

Function
REQ-018 FSM states: IDLE, RUN, PAUSE, FLAG; all outputs registered, updated one cycle after the causing input.
REQ-019 IDLE: load -> all clocks init_min:00, flag cleared, active=0; start -> RUN only if at least one clock is nonzero, else stays IDLE.
REQ-020 RUN: pause -> PAUSE; a clock reaching 00:00 -> FLAG; load ignored.
REQ-021 PAUSE: start -> RUN; load -> IDLE with load effects; pass ignored.
REQ-022 FLAG: counting halted; load -> IDLE with load effects; start, pause, pass ignored.
REQ-023 Prescaler counts 0..TICK_DIV-1 only in RUN; tick is the cycle it equals TICK_DIV-1, after which it wraps to 0.
REQ-024 Prescaler clears to 0 on entry to RUN and on every accepted pass; each move therefore starts a fresh second.
REQ-025 On tick, active clock decrements: sec>0 -> sec-1; sec=0 and min>0 -> min-1, sec=59.
REQ-026 Decrement producing 00:00 sets flag[active] and enters FLAG in the same update.
REQ-027 Accepted pass in RUN: active advances to (active+1) mod N_PLAYERS; wraps N_PLAYERS-1 -> 0.
REQ-028 mode=1: accepted pass adds inc_sec to outgoing player; sec sum >=60 subtracts 60 and carries 1 minute; minutes saturate at 63:59.
REQ-029 mode=0: pass changes active only; no time added.
REQ-030 Tick and pass in same cycle: decrement applied first, then increment and advance; if decrement flags, pass discarded.
REQ-031 Pause and pass in same cycle: pause wins, pass discarded, active unchanged.
REQ-032 Start and pause in same cycle: pause wins.
REQ-033 Non-active clocks never change except via load.

Reset
REQ-034 reset low at a clk edge: state IDLE, prescaler 0, active 0, running 0, flag 0, all min/sec 0; overrides every other input, including mid-RUN.
REQ-035 First cycle after reset release behaves as IDLE with zeroed clocks; start without prior load stays IDLE.

Structure
REQ-036 Shared package holds FSM state encoding, SEC_MAX=59, MIN_SAT=63, field width 6.
REQ-037 One sub-module, mm_ss_unit: per-player min:sec register with decrement, saturating add, and zero detect; instantiated N_PLAYERS times.

Verification (TICK_DIV=4, N_PLAYERS=3)
REQ-038 load init_min=1, start -> after 4 cycles player 0 reads 00:59; players 1,2 read 01:00.
REQ-039 mode=1, inc_sec=10, player 0 at 00:55, pass -> player 0 reads 01:05, active=1, prescaler 0.
REQ-040 Pass on player 2 -> active=0 (wrap).
REQ-041 Player 1 at 00:01, tick -> 00:00, flag=3'b010, FLAG state, running=0; later pass, start ignored.
REQ-042 Tick and pass same cycle, mode=1, inc_sec=5, player 0 at 00:10 -> 00:14, active=1; pause and pass same cycle -> PAUSE, active unchanged.
REQ-043 reset low in RUN with clocks nonzero -> next cycle all outputs zero, state IDLE.
